mdu_operand_conditioner: RTL and testbench
==========================================

# mdu_operand_conditioner

Registered operand-conditioning stage at the front of the multiply/divide unit. It accepts both source operands and the opcode over a valid/ready handshake and widens each operand to PAR+1 bits. Multiplies get sign or zero extension; signed divides get magnitude conversion plus sign bookkeeping. The conditioned pair, the result-sign flags and the divide special-case flags are presented to the iterative datapath one cycle later, with full back-pressure.

## Interface
- `PAR`, 32: operand width in bits; must be ≥ 4.
- `OPCODE_WIDTH`, 3: opcode width in bits; fixed encoding in `mdu_pkg`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous kill of the held entry; higher priority than accept.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can take a request this cycle.
- `opCode`  in  OPCODE_WIDTH  MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `operand0`  in  PAR  multiplier or dividend.
- `operand1`  in  PAR  multiplicand or divisor.
- `out_valid`  out  1  conditioned entry held.
- `out_ready`  in  1  datapath consumes the entry this cycle.
- `op0_out`, `op1_out`  out  PAR+1  conditioned operands.
- `opcode_out`  out  OPCODE_WIDTH  registered opcode.
- `neg_result`  out  1  product or quotient must be negated by the post-stage.
- `neg_rem`  out  1  remainder must be negated.
- `div_by_zero`  out  1  divide opcode with operand1 == 0.
- `div_overflow`  out  1  signed divide of most-negative value by −1.

## Operation
- Per-operand signedness (s0, s1):
  - MUL/MULH: s0=1, s1=1.
  - MULHSU: s0=1, s1=0.
  - MULHU: s0=0, s1=0.
  - DIV/REM: s0=1, s1=1.
  - DIVU/REMU: s0=0, s1=0.
- Multiply (`opCode[2]`=0): `opX_out` = {sX ? operandX[PAR-1] : 0, operandX}.
  - neg_result=0, neg_rem=0, both divide flags 0.
- Divide (`opCode[2]`=1), signed: `opX_out` = zero-extended |operandX|.
  - The most-negative value maps to 2^(PAR-1), which fits in PAR+1 bits with no overflow.
- Divide, unsigned: `opX_out` = {0, operandX}.
- Signed divide sign flags:
  - neg_result = sign0 XOR sign1, forced 0 when div_by_zero.
  - neg_rem = sign0.
- Unsigned divide: neg_result=0, neg_rem=0.
- div_by_zero = `opCode[2]` AND (operand1 == 0), for signed and unsigned alike.
- div_overflow = signed divide AND operand0 == {1,0…0} AND operand1 == all-ones.
- The block only flags special cases; it never alters the conditioned operands for them.
- Handshake:
  - Accept when in_valid && in_ready. in_ready = !out_valid || out_ready, so a simultaneous consume and accept is allowed: throughput is one entry per cycle.
  - Payload registers load only on accept and hold stable while out_valid && !out_ready.
  - out_valid is set on accept. It is cleared on consume without accept, or on flush.
- Flush:
  - Clears out_valid next edge.
  - in_ready is forced 0 during the flush cycle, so no accept occurs.
  - Payload registers are not cleared.

## Timing
- Latency 1 cycle: accept at edge n, out_valid high after edge n.
- Reset (async assert, sync-released by the top level):
  - out_valid=0, all payload outputs 0.
  - in_ready=1 once rst_n is high and flush is low.
- Reset mid-operation drops the held entry; no partial state survives.
- in_ready is combinational from out_valid, out_ready and flush only; there is no path from in_valid.
- All outputs except in_ready are registered.

## Structure
- `mdu_pkg` holds:
  - the opcode enum `mdu_op_e` with the encodings above;
  - `is_div(op)` and `operand_signed(op, idx)` helpers;
  - a typedef for the PAR+1 conditioned operand.
- One sub-module, `mdu_operand_cond_lane`, used for both operands:
  - combinational widen/abs for a single operand;
  - inputs: operand, signed flag, div flag;
  - outputs: conditioned value, sign bit.
- The top module contains the handshake register, the flag logic and flush.

## Test plan
- MULHSU, op0=0xFFFF_FFFE, op1=0x8000_0000 → after 1 cycle op0_out=0x1_FFFF_FFFE, op1_out=0x0_8000_0000, neg_result=0.
- DIV, op0=0xFFFF_FFF9 (−7), op1=0x0000_0002 → op0_out=0x0_0000_0007, op1_out=0x0_0000_0002, neg_result=1, neg_rem=1.
- DIV, op0=0x8000_0000, op1=0xFFFF_FFFF → op0_out=0x0_8000_0000, op1_out=0x0_0000_0001, div_overflow=1.
- REMU, op1=0 → div_by_zero=1, neg_result=0; op1_out=0.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and payload stable. Then out_ready=1 → consume and new accept in the same cycle, out_valid stays 1 with the new payload.
- Async reset and flush:
  - rst_n low mid-hold → out_valid=0 immediately, outputs 0.
  - flush with in_valid=1 → no accept, out_valid=0 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit front end:
// opcode encoding, operand signedness helpers and the widened operand type.
package mdu_pkg;

  localparam int MDU_PAR          = 32;
  localparam int MDU_OPCODE_WIDTH = 3;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef logic [MDU_PAR:0] mdu_cond_operand_t;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  // idx selects operand0 (0) or operand1 (1); MULHSU is the only mixed-sign case.
  function automatic logic operand_signed(input mdu_op_e op, input logic idx);
    logic result;
    case (op)
      MUL, MULH, DIV, REM: result = 1'b1;
      MULHSU:              result = ~idx;
      default:             result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mdu_operand_conditioner_if.sv
// Request/response bundle between the issue side, the operand conditioner
// and the iterative multiply/divide datapath.
interface mdu_operand_conditioner_if #(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] opCode;
  logic [PAR-1:0]          operand0;
  logic [PAR-1:0]          operand1;
  logic                    out_valid;
  logic                    out_ready;
  logic [PAR:0]            op0_out;
  logic [PAR:0]            op1_out;
  logic [OPCODE_WIDTH-1:0] opcode_out;
  logic                    neg_result;
  logic                    neg_rem;
  logic                    div_by_zero;
  logic                    div_overflow;

  modport master (
    output flush, in_valid, opCode, operand0, operand1, out_ready,
    input  in_ready, out_valid, op0_out, op1_out, opcode_out,
           neg_result, neg_rem, div_by_zero, div_overflow
  );

  modport slave (
    input  flush, in_valid, opCode, operand0, operand1, out_ready,
    output in_ready, out_valid, op0_out, op1_out, opcode_out,
           neg_result, neg_rem, div_by_zero, div_overflow
  );

endinterface

// File: rtl/mdu_operand_cond_lane.sv
// Widens one operand by a bit: sign/zero extension for multiplies,
// magnitude for signed divides (most-negative maps cleanly to 2^(PAR-1)).
module mdu_operand_cond_lane #(
  parameter int PAR = 32
) (
  input  logic [PAR-1:0] operand,
  input  logic           isSigned,
  input  logic           isDiv,
  output logic [PAR:0]   condValue,
  output logic           signBit
);

  logic [PAR-1:0] magnitude;

  always_comb begin
    signBit   = isSigned & operand[PAR-1];
    magnitude = signBit ? (~operand + PAR'(1)) : operand;
    if (isDiv) begin
      condValue = {1'b0, magnitude};
    end else begin
      condValue = {signBit, operand};
    end
  end

endmodule

// File: rtl/mdu_operand_conditioner.sv
// One-entry registered stage that conditions operands and computes sign and
// divide special-case flags ahead of the iterative multiply/divide datapath.
module mdu_operand_conditioner
  import mdu_pkg::*;
#(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mdu_operand_conditioner_if.slave bus
);

  mdu_op_e      op;
  logic         isDivOp;
  logic         signed0;
  logic         signed1;
  logic         signedDiv;
  logic [PAR:0] cond0;
  logic [PAR:0] cond1;
  logic         sign0;
  logic         sign1;
  logic         divByZero;
  logic         divOverflow;
  logic         negResult;
  logic         negRem;
  logic         accept;

  always_comb begin
    op        = mdu_op_e'(bus.opCode);
    isDivOp   = is_div(op);
    signed0   = operand_signed(op, 1'b0);
    signed1   = operand_signed(op, 1'b1);
    signedDiv = isDivOp & signed0;
  end

  mdu_operand_cond_lane #(.PAR(PAR)) lane0 (
    .operand   (bus.operand0),
    .isSigned  (signed0),
    .isDiv     (isDivOp),
    .condValue (cond0),
    .signBit   (sign0)
  );

  mdu_operand_cond_lane #(.PAR(PAR)) lane1 (
    .operand   (bus.operand1),
    .isSigned  (signed1),
    .isDiv     (isDivOp),
    .condValue (cond1),
    .signBit   (sign1)
  );

  // Special cases are only flagged; the datapath decides what to do with them.
  always_comb begin
    divByZero   = isDivOp && (bus.operand1 == '0);
    divOverflow = signedDiv && (bus.operand0 == {1'b1, {(PAR-1){1'b0}}}) && (&bus.operand1);
    negResult   = signedDiv && (sign0 ^ sign1) && !divByZero;
    negRem      = signedDiv && sign0;
  end

  assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Flush wins over consume; payload is left untouched on flush or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.op0_out      <= '0;
      bus.op1_out      <= '0;
      bus.opcode_out   <= '0;
      bus.neg_result   <= 1'b0;
      bus.neg_rem      <= 1'b0;
      bus.div_by_zero  <= 1'b0;
      bus.div_overflow <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid    <= 1'b1;
      bus.op0_out      <= cond0;
      bus.op1_out      <= cond1;
      bus.opcode_out   <= bus.opCode;
      bus.neg_result   <= negResult;
      bus.neg_rem      <= negRem;
      bus.div_by_zero  <= divByZero;
      bus.div_overflow <= divOverflow;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdu_operand_conditioner.sv
// Self-checking bench: constant vector table streamed through a scoreboard,
// plus hand-written back-pressure, reset and flush sequences.
module tb_mdu_operand_conditioner;
  import mdu_pkg::*;

  localparam int PAR = 32;
  localparam int OW  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mdu_operand_conditioner_if #(.PAR(PAR), .OPCODE_WIDTH(OW)) bus ();

  mdu_operand_conditioner #(.PAR(PAR), .OPCODE_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // flags = {neg_result, neg_rem, div_by_zero, div_overflow}
  typedef struct {
    mdu_op_e           op;
    logic [PAR-1:0]    a;
    logic [PAR-1:0]    b;
    mdu_cond_operand_t e0;
    mdu_cond_operand_t e1;
    logic [3:0]        flags;
  } vec_t;

  typedef struct {
    mdu_op_e           op;
    mdu_cond_operand_t e0;
    mdu_cond_operand_t e1;
    logic [3:0]        flags;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dutFlags();
    return {bus.neg_result, bus.neg_rem, bus.div_by_zero, bus.div_overflow};
  endfunction

  // Scoreboard side: an entry leaves the stage whenever valid and ready meet.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedOutput: got op0_out 0x%0h expected no entry", bus.op0_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("op0_out", 64'(bus.op0_out), 64'(e.e0));
        checkOutput("op1_out", 64'(bus.op1_out), 64'(e.e1));
        checkOutput("opcode_out", 64'(bus.opcode_out), 64'(e.op));
        checkOutput("flags", 64'(dutFlags()), 64'(e.flags));
      end
    end
  end

  task automatic driveInputs(input vec_t v);
    bus.opCode   = v.op;
    bus.operand0 = v.a;
    bus.operand1 = v.b;
    bus.in_valid = 1'b1;
  endtask

  function automatic exp_t toExp(input vec_t v);
    exp_t e;
    e.op = v.op; e.e0 = v.e0; e.e1 = v.e1; e.flags = v.flags;
    return e;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bit done = 0;
    driveInputs(v);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sbq.push_back(toExp(v));
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL acceptTimeout: got in_ready 0 expected 1 within 20 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vec_t fl;
    vecs[0]  = '{MULHSU, 32'hFFFF_FFFE, 32'h8000_0000, 33'h1_FFFF_FFFE, 33'h0_8000_0000, 4'b0000};
    vecs[1]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 33'h0_0000_0007, 33'h0_0000_0002, 4'b1100};
    vecs[2]  = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 33'h0_8000_0000, 33'h0_0000_0001, 4'b0101};
    vecs[3]  = '{REMU,   32'h0000_0005, 32'h0000_0000, 33'h0_0000_0005, 33'h0_0000_0000, 4'b0010};
    vecs[4]  = '{MUL,    32'h8000_0000, 32'h7FFF_FFFF, 33'h1_8000_0000, 33'h0_7FFF_FFFF, 4'b0000};
    vecs[5]  = '{MULHU,  32'hFFFF_FFFF, 32'h8000_0000, 33'h0_FFFF_FFFF, 33'h0_8000_0000, 4'b0000};
    vecs[6]  = '{REM,    32'h0000_0007, 32'hFFFF_FFFD, 33'h0_0000_0007, 33'h0_0000_0003, 4'b1000};
    vecs[7]  = '{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 33'h0_8000_0000, 33'h0_FFFF_FFFF, 4'b0000};
    vecs[8]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0000, 33'h0_0000_0007, 33'h0_0000_0000, 4'b0110};
    vecs[9]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 4'b0000};
    vecs[10] = '{DIVU,   32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000, 33'h0_0000_0000, 4'b0010};
    vecs[11] = '{REM,    32'h8000_0000, 32'h8000_0000, 33'h0_8000_0000, 33'h0_8000_0000, 4'b0100};

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opCode = '0; bus.operand0 = '0; bus.operand1 = '0;

    #3;
    checkOutput("resetOutValid", 64'(bus.out_valid), 64'd0);
    checkOutput("resetOp0", 64'(bus.op0_out), 64'd0);
    checkOutput("resetFlags", 64'(dutFlags()), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetInReady", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    $display("[TB] streaming vector table");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("[TB] back-pressure sequence");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[1]);
    driveInputs(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bpInReady", 64'(bus.in_ready), 64'd0);
      checkOutput("bpHoldOp0", 64'(bus.op0_out), 64'(vecs[1].e0));
      checkOutput("bpHoldFlags", 64'(dutFlags()), 64'(vecs[1].flags));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpReadyAgain", 64'(bus.in_ready), 64'd1);
    sbq.push_back(toExp(vecs[0]));
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bpStillValid", 64'(bus.out_valid), 64'd1);
    checkOutput("bpNewOp0", 64'(bus.op0_out), 64'(vecs[0].e0));
    @(posedge clk); #1;

    $display("[TB] async reset mid-hold");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[4]);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("rstOutValid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstOp0", 64'(bus.op0_out), 64'd0);
    checkOutput("rstOp1", 64'(bus.op1_out), 64'd0);
    checkOutput("rstOpcode", 64'(bus.opcode_out), 64'd0);
    checkOutput("rstFlags", 64'(dutFlags()), 64'd0);
    sbq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReleaseReady", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    $display("[TB] flush while consuming with a request pending");
    applyStimulus(vecs[7]);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    driveInputs(vecs[9]);
    @(negedge clk);
    checkOutput("flushInReady", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("flushOutValid", 64'(bus.out_valid), 64'd0);
    checkOutput("flushPayloadKept", 64'(bus.op0_out), 64'(vecs[7].e0));

    $display("[TB] flush of a stalled entry");
    @(posedge clk); #1;
    fl = vecs[2];
    applyStimulus(fl);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    sbq.delete();
    @(negedge clk);
    checkOutput("flushHeldValid", 64'(bus.out_valid), 64'd0);
    checkOutput("flushHeldInReady", 64'(bus.in_ready), 64'd1);

    for (int c = 0; c < 20 && sbq.size() != 0; c++) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
